// File: rtl/y86_decode.sv
// rtl/y86_decode.sv - Y86 decode stage: regfile, D/E pipeline register, pending-write scoreboard.
// Optional macro Y86_DEC_BYPASS_EN: forward a same-cycle write-back to the source operands.
module y86_decode #(
  parameter int         WORD_W = 32,
  parameter logic [7:0] RNONE  = 8'h0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [7:0]        f_icode,
  input  logic [7:0]        f_ifun,
  input  logic [7:0]        f_rA,
  input  logic [7:0]        f_rB,
  input  logic [WORD_W-1:0] f_valC,
  input  logic              e_ready,
  output logic              e_valid,
  output logic [7:0]        icode_o,
  output logic [7:0]        ifun_o,
  output logic [WORD_W-1:0] valA_o,
  output logic [WORD_W-1:0] valB_o,
  output logic [WORD_W-1:0] valC_o,
  output logic [7:0]        dstE_o,
  input  logic              wb_en,
  input  logic [7:0]        wb_dst,
  input  logic [WORD_W-1:0] wb_val,
  output logic              halted,
  output logic              err
);

  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;

  logic [WORD_W-1:0] rf [8];
  logic [7:0]        pending;

  logic [7:0]        icode_d, ifun_d, src_a, src_b, dst_d;
  logic              known;
  logic              a_ok, b_ok, wb_ok, hit_a, hit_b, haz_a, haz_b, stall, xfer;
  logic [WORD_W-1:0] op_a, op_b;
  logic [7:0]        set_mask, clr_mask;

  always_comb begin
    icode_d = f_icode;
    ifun_d  = f_ifun;
    src_a   = RNONE;
    src_b   = RNONE;
    dst_d   = RNONE;
    known   = 1'b1;
    case (f_icode)
      8'd0, 8'd1: ;
      8'd2: begin src_a = f_rA; dst_d = f_rB; end
      8'd3: dst_d = f_rB;
      8'd6: begin src_a = f_rA; src_b = f_rB; dst_d = f_rB; end
      default: begin icode_d = 8'd1; ifun_d = 8'd0; known = 1'b0; end
    endcase
  end

  assign a_ok  = src_a < 8'd8;
  assign b_ok  = src_b < 8'd8;
  assign wb_ok = wb_en && (wb_dst < 8'd8);
  assign hit_a = wb_ok && a_ok && (wb_dst[2:0] == src_a[2:0]);
  assign hit_b = wb_ok && b_ok && (wb_dst[2:0] == src_b[2:0]);

`ifdef Y86_DEC_BYPASS_EN
  // A write landing this cycle satisfies the dependency; its value is forwarded.
  assign haz_a = a_ok && pending[src_a[2:0]] && !hit_a;
  assign haz_b = b_ok && pending[src_b[2:0]] && !hit_b;
  assign op_a  = !a_ok ? '0 : (hit_a ? wb_val : rf[src_a[2:0]]);
  assign op_b  = !b_ok ? '0 : (hit_b ? wb_val : rf[src_b[2:0]]);
`else
  // Without forwarding, a same-cycle write must land in the regfile first.
  assign haz_a = a_ok && (pending[src_a[2:0]] || hit_a);
  assign haz_b = b_ok && (pending[src_b[2:0]] || hit_b);
  assign op_a  = a_ok ? rf[src_a[2:0]] : '0;
  assign op_b  = b_ok ? rf[src_b[2:0]] : '0;
`endif

  assign stall   = f_valid && (haz_a || haz_b);
  assign f_ready = !halted && !stall && (!e_valid || e_ready);
  assign xfer    = f_valid && f_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (xfer && dst_d < 8'd8) set_mask[dst_d[2:0]] = 1'b1;
    if (wb_ok)                clr_mask[wb_dst[2:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (wb_ok) rf[wb_dst[2:0]] <= wb_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      icode_o <= '0;
      ifun_o  <= '0;
      valA_o  <= '0;
      valB_o  <= '0;
      valC_o  <= '0;
      dstE_o  <= RNONE;
      err     <= 1'b0;
    end else begin
      if (xfer) begin
        e_valid <= 1'b1;
        icode_o <= icode_d;
        ifun_o  <= ifun_d;
        valA_o  <= op_a;
        valB_o  <= op_b;
        valC_o  <= f_valC;
        dstE_o  <= (dst_d < 8'd8) ? dst_d : RNONE;
        if (!known) err <= 1'b1;
      end else if (e_ready) begin
        e_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && xfer && f_icode == 8'd0) state_d = HALTED;
  end

  always_comb begin
    halted = (state_q == HALTED);
  end

endmodule
